// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the multi-cycle control unit.
//   - 5-bit opcode constants (IR[31:27])
//   - FSM state encodings (exported on state_view)
//   - instruction-class enum produced by cu_decoder
//   - strobes_t: every datapath control strobe, MSB first in port order
package cu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [5:0] {
    S_T0   = 6'd0,
    S_T1   = 6'd1,
    S_T2   = 6'd2,
    S_T3   = 6'd3,
    S_T4   = 6'd4,
    S_T5   = 6'd5,
    S_T6   = 6'd6,
    S_T7   = 6'd7,
    S_DIVW = 6'd8,
    S_HALT = 6'd63
  } state_e;

  typedef enum logic [4:0] {
    C_ALU, C_IMM, C_LD, C_LDI, C_ST, C_MUL, C_DIV, C_UNARY,
    C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } cls_e;

  typedef struct packed {
    logic gra, grb, grc, rin, r_out, ba_out;
    logic pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, c_out, in_out;
    logic pc_rd, ir_rd, mar_rd, mdr_rd, y_rd, zhi_rd, zlo_rd, hi_rd, lo_rd, out_rd;
    logic inc_pc, read, write, reset_div;
  } strobes_t;

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: combinational opcode -> instruction class and ALU op_sel.
//   opcode_i  in   5  IR[31:27]
//   cls_o     out     instruction class (undefined opcodes decode as C_NOP)
//   op_sel_o  out  5  ALU operation for the execute step of this class
module cu_decoder
  import cu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output cls_e       cls_o,
  output logic [4:0] op_sel_o
);

  always_comb begin
    cls_o    = C_NOP;
    op_sel_o = OP_ADD;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
        cls_o    = C_ALU;
        op_sel_o = opcode_i;
      end
      // Immediate forms reuse the register-form ALU operation.
      OP_ADDI: begin cls_o = C_IMM; op_sel_o = OP_ADD; end
      OP_ANDI: begin cls_o = C_IMM; op_sel_o = OP_AND; end
      OP_ORI:  begin cls_o = C_IMM; op_sel_o = OP_OR;  end
      OP_LD:   cls_o = C_LD;
      OP_LDI:  cls_o = C_LDI;
      OP_ST:   cls_o = C_ST;
      OP_MUL:  begin cls_o = C_MUL; op_sel_o = OP_MUL; end
      OP_DIV:  begin cls_o = C_DIV; op_sel_o = OP_DIV; end
      OP_NEG, OP_NOT: begin
        cls_o    = C_UNARY;
        op_sel_o = opcode_i;
      end
      OP_BR:   cls_o = C_BR;
      OP_JR:   cls_o = C_JR;
      OP_JAL:  cls_o = C_JAL;
      OP_IN:   cls_o = C_IN;
      OP_OUT:  cls_o = C_OUT;
      OP_MFHI: cls_o = C_MFHI;
      OP_MFLO: cls_o = C_MFLO;
      OP_HALT: cls_o = C_HALT;
      default: cls_o = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hard-wired multi-cycle control FSM for the single-bus datapath.
// Fetch T0-T2, decode T3, execute T3..T7 / S_DIVW, then back to S_T0.
// Ports:
//   clk, clr_n (async active-low), stop (halt at next T0)
//   step (only with CU_SINGLE_STEP_EN: one instruction per rising edge)
//   IR_view[31:0], con_ff_view, calc_finished  - datapath feedback
//   Gra..BAout, *_out bus drivers, *_rd loads, IncPC, Read, Write,
//   reset_div, op_sel[4:0]  - datapath controls
//   run (low only in S_HALT), state_view[5:0] (current state)
// Parameters: MEM_WAIT (0-3 extra Read cycles before MDR_rd),
//   DIV_TIMEOUT (max cycles in S_DIVW before Z is loaded anyway).
// Optional build macro: CU_SINGLE_STEP_EN.
module control_unit
  import cu_pkg::*;
#(
  parameter int MEM_WAIT    = 1,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        stop,
`ifdef CU_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] IR_view,
  input  logic        con_ff_view,
  input  logic        calc_finished,
  output logic        Gra, Grb, Grc, Rin, R_out, BAout,
  output logic        PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out, C_out, In_out,
  output logic        PC_rd, IR_rd, MAR_rd, MDR_rd, Y_rd, Zhi_rd, Zlo_rd, HI_rd, LO_rd, Out_rd,
  output logic        IncPC, Read, Write, reset_div,
  output logic [4:0]  op_sel,
  output logic        run,
  output logic [5:0]  state_view
);

  localparam logic [1:0] MW       = 2'(MEM_WAIT);
  localparam int         DW       = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [1:0]    wait_q, wait_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          cond_q, cond_d;
  logic          step_go;
  strobes_t      strb, strb_out;
  logic [4:0]    op;
  cls_e          cls;
  logic [4:0]    dec_op;
  logic          unused_ir;

  assign unused_ir = ^IR_view[26:0];

  cu_decoder u_dec (
    .opcode_i (IR_view[31:27]),
    .cls_o    (cls),
    .op_sel_o (dec_op)
  );

`ifdef CU_SINGLE_STEP_EN
  // A step edge seen mid-instruction is remembered so it is not lost.
  logic step_q, step_pend_q, step_pend_d;
  assign step_go = step_pend_q | (step & ~step_q);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      step_q      <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_q      <= step;
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign step_go = 1'b1;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_T0;
      wait_q    <= '0;
      div_cnt_q <= '0;
      cond_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      div_cnt_q <= div_cnt_d;
      cond_q    <= cond_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    div_cnt_d = div_cnt_q;
    cond_d    = cond_q;
    strb      = '0;
    op        = OP_ADD;
`ifdef CU_SINGLE_STEP_EN
    step_pend_d = step_go;
`endif
    case (state_q)
      S_T0: begin
        if (stop) begin
          state_d = S_HALT;
        end else if (step_go) begin
          strb.pc_out = 1'b1; strb.mar_rd = 1'b1; strb.inc_pc = 1'b1;
          wait_d  = '0;
          state_d = S_T1;
`ifdef CU_SINGLE_STEP_EN
          step_pend_d = 1'b0;
`endif
        end
      end
      S_T1: begin
        // Read held MEM_WAIT cycles, then Read + MDR_rd together.
        strb.read = 1'b1;
        if (wait_q == MW) begin
          strb.mdr_rd = 1'b1; wait_d = '0; state_d = S_T2;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_T2: begin
        strb.mdr_out = 1'b1; strb.ir_rd = 1'b1; state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T4;
        case (cls)
          C_ALU, C_IMM, C_MUL, C_DIV: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.y_rd = 1'b1; end
          C_LD, C_LDI, C_ST: begin strb.grb = 1'b1; strb.ba_out = 1'b1; strb.y_rd = 1'b1; end
          C_UNARY: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.zlo_rd = 1'b1; op = dec_op; end
          C_BR: begin strb.gra = 1'b1; strb.r_out = 1'b1; cond_d = con_ff_view; end
          C_JAL: begin strb.pc_out = 1'b1; strb.grb = 1'b1; strb.rin = 1'b1; end
          C_JR: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_rd = 1'b1; state_d = S_T0; end
          C_IN: begin strb.in_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; state_d = S_T0; end
          C_OUT: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.out_rd = 1'b1; state_d = S_T0; end
          C_MFHI: begin strb.hi_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; state_d = S_T0; end
          C_MFLO: begin strb.lo_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; state_d = S_T0; end
          C_HALT: state_d = S_HALT;
          default: state_d = S_T0;
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (cls)
          C_ALU: begin strb.grc = 1'b1; strb.r_out = 1'b1; strb.zlo_rd = 1'b1; op = dec_op; end
          C_IMM: begin strb.c_out = 1'b1; strb.zlo_rd = 1'b1; op = dec_op; end
          C_LD, C_LDI, C_ST: begin strb.c_out = 1'b1; strb.zlo_rd = 1'b1; end
          C_MUL: begin
            strb.grc = 1'b1; strb.r_out = 1'b1; strb.zhi_rd = 1'b1; strb.zlo_rd = 1'b1; op = dec_op;
          end
          C_DIV: begin strb.reset_div = 1'b1; div_cnt_d = '0; state_d = S_DIVW; end
          C_UNARY: begin strb.zlo_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; state_d = S_T0; end
          C_BR: begin strb.pc_out = 1'b1; strb.y_rd = 1'b1; end
          C_JAL: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_rd = 1'b1; state_d = S_T0; end
          default: state_d = S_T0;
        endcase
      end
      S_DIVW: begin
        // Operands stay on the bus until the divider reports done or
        // the timeout expires; Z is captured in the exit cycle either way.
        strb.grc = 1'b1; strb.r_out = 1'b1; op = dec_op;
        div_cnt_d = div_cnt_q + 1'b1;
        if (calc_finished || (div_cnt_q == DIV_LAST)) begin
          strb.zhi_rd = 1'b1; strb.zlo_rd = 1'b1; state_d = S_T5;
        end
      end
      S_T5: begin
        state_d = S_T0;
        case (cls)
          C_ALU, C_IMM, C_LDI: begin strb.zlo_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
          C_LD, C_ST: begin strb.zlo_out = 1'b1; strb.mar_rd = 1'b1; wait_d = '0; state_d = S_T6; end
          C_MUL, C_DIV: begin strb.zlo_out = 1'b1; strb.lo_rd = 1'b1; state_d = S_T6; end
          C_BR: begin strb.c_out = 1'b1; strb.zlo_rd = 1'b1; state_d = S_T6; end
          default: state_d = S_T0;
        endcase
      end
      S_T6: begin
        state_d = S_T0;
        case (cls)
          C_LD: begin
            strb.read = 1'b1;
            state_d   = S_T6;
            if (wait_q == MW) begin
              strb.mdr_rd = 1'b1; wait_d = '0; state_d = S_T7;
            end else begin
              wait_d = wait_q + 2'd1;
            end
          end
          C_ST: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.mdr_rd = 1'b1; state_d = S_T7; end
          C_MUL, C_DIV: begin strb.zhi_out = 1'b1; strb.hi_rd = 1'b1; end
          C_BR: begin
            if (cond_q) begin strb.zlo_out = 1'b1; strb.pc_rd = 1'b1; end
          end
          default: state_d = S_T0;
        endcase
      end
      S_T7: begin
        state_d = S_T0;
        if (cls == C_LD) begin
          strb.mdr_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1;
        end else if (cls == C_ST) begin
          strb.write = 1'b1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_T0;
    endcase
  end

  // Strobes are decoded from state; forcing them low while clr_n is held
  // guarantees no datapath write can happen during an aborting reset.
  assign strb_out = clr_n ? strb : '0;
  assign {Gra, Grb, Grc, Rin, R_out, BAout,
          PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out, C_out, In_out,
          PC_rd, IR_rd, MAR_rd, MDR_rd, Y_rd, Zhi_rd, Zlo_rd, HI_rd, LO_rd, Out_rd,
          IncPC, Read, Write, reset_div} = strb_out;
  assign op_sel     = clr_n ? op : OP_ADD;
  assign run        = (state_q != S_HALT);
  assign state_view = state_q;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hard-wired multi-cycle control FSM for the single-bus datapath.
- Sequences fetch, decode and execute by driving every datapath control strobe: register select, bus-write enables, register-load enables, memory Read/Write, op_sel, IncPC and reset_div.
- Consumes IR, con_ff_view and calc_finished back from the datapath.
- Sits beside the datapath in the top-level CPU.

Parameters:
- MEM_WAIT, 1, extra Read-held cycles before MDR_rd on any memory read (synchronous memory latency); range 0-3.
- DIV_TIMEOUT, 64, maximum cycles waited for calc_finished before the FSM forces completion.

Ports:
- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- stop  in  1  request halt at next fetch boundary
- IR_view  in  32  instruction register contents; opcode = IR_view[31:27]
- con_ff_view  in  1  branch condition from CON_FF (combinational on bus)
- calc_finished  in  1  divider done
- Gra, Grb, Grc, Rin, R_out, BAout  out  1 each  select-and-encode controls
- PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out, C_out, In_out  out  1 each  bus drivers
- PC_rd, IR_rd, MAR_rd, MDR_rd, Y_rd, Zhi_rd, Zlo_rd, HI_rd, LO_rd, Out_rd  out  1 each  register loads
- IncPC, Read, Write, reset_div  out  1 each
- op_sel  out  5  ALU operation
- run  out  1  high while not halted
- state_view  out  6  current state encoding

Behaviour:
- Reset:
  - All strobes are 0, op_sel = OP_ADD, run = 1, state = S_T0.
  - Reset is asynchronous; asserting it mid-instruction aborts the instruction with no partial register writes after assertion.
- At most one bus-write enable is high in any cycle (one-hot bus); the bench asserts this continuously.
- Fetch:
  - T0: PC_out, MAR_rd, IncPC.
  - T1: Read held for MEM_WAIT cycles (counter), then Read + MDR_rd.
  - T2: MDR_out, IR_rd.
  - T3: decode.
- ALU register ops (add, sub, and, or, shr, shra, shl, ror, rol; opcodes 00011-01011):
  - T3: Grb, R_out, Y_rd.
  - T4: Grc, R_out, op_sel = opcode, Zlo_rd.
  - T5: Zlo_out, Gra, Rin.
  - Total 6 + MEM_WAIT cycles.
- Immediate ops (addi, andi, ori): as register ops, except T4 uses C_out in place of Grc/R_out.
- ld / ldi:
  - T3: Grb, BAout, Y_rd.
  - T4: C_out, op_sel = OP_ADD, Zlo_rd.
  - ldi T5: Zlo_out, Gra, Rin.
  - ld T5: Zlo_out, MAR_rd; then read wait as in T1; T7: MDR_out, Gra, Rin.
- st:
  - Address computed as for ld.
  - T5: Zlo_out, MAR_rd.
  - T6: Gra, R_out, MDR_rd (Read = 0).
  - T7: Write for exactly 1 cycle.
- mul:
  - T3: Grb, R_out, Y_rd.
  - T4: Grc, R_out, op_sel = mul, Zhi_rd, Zlo_rd.
  - T5: Zlo_out, LO_rd.
  - T6: Zhi_out, HI_rd.
- div:
  - T3 as mul.
  - T4: reset_div for 1 cycle.
  - S_DIVW: Grc, R_out, op_sel = div held until calc_finished = 1; Zhi_rd and Zlo_rd are asserted in that same cycle.
  - If DIV_TIMEOUT elapses first, the FSM loads Z anyway.
  - Then T5/T6 as mul.
- neg / not:
  - T3: Grb, R_out, op_sel, Zlo_rd.
  - T4: Zlo_out, Gra, Rin.
- Branch:
  - T3: Gra, R_out; con_ff_view is latched into an internal cond register.
  - T4: PC_out, Y_rd.
  - T5: C_out, OP_ADD, Zlo_rd.
  - T6: if cond, Zlo_out, PC_rd; otherwise no strobes.
- jr: T3: Gra, R_out, PC_rd.
- jal: T3: PC_out, Grb-selected R15 (Rin forced via BAout=0 link path), then as jr.
- in: T3: In_out, Gra, Rin.
- out: T3: Gra, R_out, Out_rd.
- mfhi / mflo: T3: HI_out or LO_out, Gra, Rin.
- nop: return to T0 after T3.
- halt, or stop sampled high in T0: enter S_HALT, run = 0, all strobes 0; remain there until reset.
- Undefined opcode: treated as nop.
- Every instruction returns to S_T0 on its last step.

Optional Feature:
- CU_SINGLE_STEP_EN defined:
  - Adds input `step`.
  - FSM waits in S_T0 until a rising edge of step is detected, so one instruction runs per step pulse.
  - stop and halt still take priority.
- CU_SINGLE_STEP_EN undefined: no `step` port; free-running.

Decomposition:
- Package cu_pkg holds:
  - 5-bit opcode localparams (OP_LD=00000, OP_LDI=00001, OP_ST=00010, OP_ADD=00011 ... OP_MFLO=11001, OP_NOP=11010, OP_HALT=11011).
  - State encodings.
  - Instruction-class enum.
- Sub-module cu_decoder: combinational opcode to class mapping plus op_sel. FSM and counters stay in control_unit.

Test Plan:
- Reset mid-fetch: clr_n low at T1 -> all strobes 0 and state = S_T0 within the same cycle; run = 1.
- add R1,R2,R3 with R2 = 5, R3 = 7, MEM_WAIT = 1 -> strobe sequence exactly as specified; R1 = 12 after 7 cycles; op_sel = 00011 in T4.
- ld R4,0x54(R0) with mem[0x54] = 0x97 -> BAout asserted in T3; R4 = 0x97; no Write asserted.
- div with calc_finished after 33 cycles -> reset_div pulses once; HI/LO loaded; DIV_TIMEOUT = 10 forces exit at cycle 10.
- brzr R5 with R5 = 0, then R5 = 3 -> PC_rd asserted only in the first case; PC = PC + 1 + C.
- halt opcode, and separately stop = 1 during an instruction -> S_HALT entered at the next T0; run = 0; no strobes for 100 cycles.
